// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide writeback unit.
package multdiv_pkg;

   localparam int unsigned XLEN            = 32;
   localparam int unsigned ITER_COUNT      = 32;
   localparam int unsigned RSTATUS_REG_DEF = 30;
   localparam int unsigned RSTATUS_MUL     = 4;
   localparam int unsigned RSTATUS_DIV     = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MULT,
      ST_DIV,
      ST_DONE
   } state_t;

   // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned 2^31.
   function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v);
      return v[XLEN-1] ? (~v + XLEN'(1)) : v;
   endfunction

endpackage

// File: rtl/div_nonrestoring_core.sv
// Unsigned non-restoring divider: one quotient bit per step on magnitudes.
module div_nonrestoring_core #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient
);

   // Two spare bits keep the shifted partial remainder (up to 2*divisor) in range.
   localparam int unsigned RW = WIDTH + 2;

   logic [RW-1:0]    rem;
   logic [RW-1:0]    shifted;
   logic [RW-1:0]    rem_next;
   logic [WIDTH-1:0] dvs;

   always_comb begin
      shifted = {rem[RW-2:0], quotient[WIDTH-1]};
      if (rem[RW-1]) rem_next = shifted + RW'(dvs);
      else           rem_next = shifted - RW'(dvs);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem      <= '0;
         dvs      <= '0;
         quotient <= '0;
      end else if (load) begin
         rem      <= '0;
         dvs      <= divisor;
         quotient <= dividend;
      end else if (step) begin
         rem      <= rem_next;
         quotient <= {quotient[WIDTH-2:0], ~rem_next[RW-1]};
      end
   end

endmodule

// File: rtl/multdiv_wb.sv
// Iterative signed 32-bit multiply/divide unit emitting one register-file writeback beat.
// Define MULTDIV_DIV_EN to build the divider; without it DIV completes as an exception.
module multdiv_wb
   import multdiv_pkg::*;
#(
   parameter int unsigned WIDTH       = XLEN,
   parameter int unsigned RSTATUS_REG = RSTATUS_REG_DEF
) (
   input  logic             clock,
   input  logic             ctrl_reset_n,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [4:0]       ctrl_writeReg,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic             busy,
   output logic             data_resultRDY,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             wb_writeEnable,
   output logic [4:0]       wb_writeReg,
   output logic [WIDTH-1:0] wb_data
);

   localparam int unsigned PW = 2*WIDTH + 2;
   localparam int unsigned CW = 6;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic             op_div;
   logic [4:0]       rd;
   logic [WIDTH-1:0] mcand;
   logic [PW-1:0]    prod;
   logic [PW-1:0]    prod_next;
   logic [WIDTH:0]   hi_sum;
   logic             accept;
   logic             iter_done;
   logic             mult_ovf;
   logic [WIDTH-1:0] fin_result;
   logic [WIDTH-1:0] fin_code;
   logic             fin_exc;

   assign accept    = ((state == ST_IDLE) || (state == ST_DONE)) && (ctrl_MULT ^ ctrl_DIV);
   assign iter_done = (cnt == CW'(ITER_COUNT));

   // Booth step: prod = {33-bit high, 32-bit multiplier, q(-1)}; 33-bit high absorbs -(-2^31).
   always_comb begin
      hi_sum = prod[PW-1:WIDTH+1];
      case (prod[1:0])
         2'b01:   hi_sum = hi_sum + {mcand[WIDTH-1], mcand};
         2'b10:   hi_sum = hi_sum - {mcand[WIDTH-1], mcand};
         default: ;
      endcase
      prod_next = {hi_sum[WIDTH], hi_sum, prod[WIDTH:1]};
   end

   // Product bits [63:31] live at prod[64:32]; they must all agree for a 32-bit fit.
   assign mult_ovf = ~((&prod[2*WIDTH:WIDTH]) | ~(|prod[2*WIDTH:WIDTH]));

`ifdef MULTDIV_DIV_EN
   logic             start_div;
   logic             div_neg;
   logic             div_zero;
   logic             div_ovf;
   logic [WIDTH-1:0] quot;
   logic [WIDTH-1:0] quot_signed;

   assign start_div = accept && ctrl_DIV;

   div_nonrestoring_core #(.WIDTH(WIDTH)) u_div (
      .clk      (clock),
      .rst_n    (ctrl_reset_n),
      .load     (start_div),
      .step     ((state == ST_DIV) && !iter_done),
      .dividend (magnitude(data_operandA)),
      .divisor  (magnitude(data_operandB)),
      .quotient (quot)
   );

   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         div_neg  <= 1'b0;
         div_zero <= 1'b0;
         div_ovf  <= 1'b0;
      end else if (start_div) begin
         div_neg  <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         div_zero <= (data_operandB == '0);
         div_ovf  <= (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
      end
   end

   assign quot_signed = div_neg ? (~quot + WIDTH'(1)) : quot;
`endif

   // Final result and exception selection, registered on the transition into DONE.
   always_comb begin
      fin_result = prod[WIDTH:1];
      fin_exc    = mult_ovf;
      fin_code   = WIDTH'(RSTATUS_MUL);
      if (op_div) begin
         fin_code = WIDTH'(RSTATUS_DIV);
`ifdef MULTDIV_DIV_EN
         fin_exc = div_zero | div_ovf;
         if (div_zero)     fin_result = '0;
         else if (div_ovf) fin_result = {1'b1, {(WIDTH-1){1'b0}}};
         else              fin_result = quot_signed;
`else
         fin_exc    = 1'b1;
         fin_result = '0;
`endif
      end
   end

   always_ff @(posedge clock or negedge ctrl_reset_n) begin
      if (!ctrl_reset_n) begin
         state          <= ST_IDLE;
         cnt            <= '0;
         op_div         <= 1'b0;
         rd             <= '0;
         mcand          <= '0;
         prod           <= '0;
         busy           <= 1'b0;
         data_resultRDY <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         wb_writeEnable <= 1'b0;
         wb_writeReg    <= '0;
         wb_data        <= '0;
      end else begin
         busy           <= 1'b0;
         data_resultRDY <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         wb_writeEnable <= 1'b0;
         wb_writeReg    <= '0;
         wb_data        <= '0;
         case (state)
            ST_IDLE, ST_DONE: begin
               state <= ST_IDLE;
               if (accept) begin
                  state  <= ctrl_DIV ? ST_DIV : ST_MULT;
                  cnt    <= '0;
                  op_div <= ctrl_DIV;
                  rd     <= ctrl_writeReg;
                  mcand  <= data_operandA;
                  prod   <= {{(WIDTH+1){1'b0}}, data_operandB, 1'b0};
                  busy   <= 1'b1;
               end
            end
            ST_MULT, ST_DIV: begin
               if (iter_done) begin
                  state          <= ST_DONE;
                  data_resultRDY <= 1'b1;
                  data_result    <= fin_result;
                  data_exception <= fin_exc;
                  wb_writeEnable <= fin_exc | (rd != '0);
                  wb_writeReg    <= fin_exc ? 5'(RSTATUS_REG) : rd;
                  wb_data        <= fin_exc ? fin_code : fin_result;
               end else begin
                  busy <= 1'b1;
                  cnt  <= cnt + CW'(1);
                  if (state == ST_MULT) prod <= prod_next;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multdiv_wb.sv
// Scoreboard bench for multdiv_wb: directed vectors push expected beats, a monitor checks them.
module tb_multdiv_wb;

`ifdef MULTDIV_DIV_EN
   localparam bit DIV_ON = 1'b1;
`else
   localparam bit DIV_ON = 1'b0;
`endif

   typedef struct {
      logic [31:0] result;
      logic        exc;
      logic        we;
      logic [4:0]  wreg;
      logic [31:0] wdata;
      int          cyc;
   } exp_t;

   logic        clock;
   logic        ctrl_reset_n;
   logic        ctrl_MULT;
   logic        ctrl_DIV;
   logic [4:0]  ctrl_writeReg;
   logic [31:0] data_operandA;
   logic [31:0] data_operandB;
   logic        busy;
   logic        data_resultRDY;
   logic [31:0] data_result;
   logic        data_exception;
   logic        wb_writeEnable;
   logic [4:0]  wb_writeReg;
   logic [31:0] wb_data;

   exp_t sb[$];
   exp_t mon_e;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   multdiv_wb dut (
      .clock          (clock),
      .ctrl_reset_n   (ctrl_reset_n),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .ctrl_writeReg  (ctrl_writeReg),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .busy           (busy),
      .data_resultRDY (data_resultRDY),
      .data_result    (data_result),
      .data_exception (data_exception),
      .wb_writeEnable (wb_writeEnable),
      .wb_writeReg    (wb_writeReg),
      .wb_data        (wb_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every beat must match the oldest expectation, at its exact cycle.
   always @(negedge clock) begin
      if (ctrl_reset_n) begin
         if (data_resultRDY) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_beat: got wb_data %h wb_writeReg %0d expected no beat", wb_data, wb_writeReg);
            end else begin
               mon_e = sb.pop_front();
               check("latency",     32'(cyc),            32'(mon_e.cyc));
               check("data_result", data_result,         mon_e.result);
               check("exception",   32'(data_exception), 32'(mon_e.exc));
               check("wb_we",       32'(wb_writeEnable), 32'(mon_e.we));
               check("wb_reg",      32'(wb_writeReg),    32'(mon_e.wreg));
               check("wb_data",     wb_data,             mon_e.wdata);
               check("busy_done",   32'(busy),           32'd0);
            end
         end else begin
            check("we_outside_done", 32'(wb_writeEnable), 32'd0);
         end
      end
   end

   task automatic issue_now(input bit is_div, input logic [4:0] rd, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] res, input bit exc,
                            input bit push);
      exp_t e;
      ctrl_MULT     = !is_div;
      ctrl_DIV      = is_div;
      ctrl_writeReg = rd;
      data_operandA = a;
      data_operandB = b;
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      ctrl_DIV  = 1'b0;
      if (is_div && !DIV_ON) begin
         res = '0;
         exc = 1'b1;
      end
      e.result = res;
      e.exc    = exc;
      e.we     = exc || (rd != 5'd0);
      e.wreg   = exc ? 5'd30 : rd;
      e.wdata  = exc ? (is_div ? 32'd5 : 32'd4) : res;
      e.cyc    = cyc + 33;
      if (push) sb.push_back(e);
   endtask

   task automatic issue(input bit is_div, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] res, input bit exc);
      @(negedge clock);
      issue_now(is_div, rd, a, b, res, exc, 1'b1);
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
      @(posedge clock);
      check("drain", 32'(sb.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1);
   end

   initial begin
      ctrl_reset_n  = 1'b0;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      ctrl_writeReg = '0;
      data_operandA = '0;
      data_operandB = '0;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rdy",  32'(data_resultRDY), 32'd0);
      check("rst_we",   32'(wb_writeEnable), 32'd0);
      check("rst_data", wb_data, 32'd0);
      repeat (3) @(negedge clock);
      ctrl_reset_n = 1'b1;

      // Multiply vectors
      issue(1'b0, 5'd8,  32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0);
      drain();
      issue(1'b0, 5'd9,  32'h00010000, 32'h00010000, 32'h00000000, 1'b1);
      drain();
      issue(1'b0, 5'd14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
      drain();
      issue(1'b0, 5'd0,  32'd4,        32'd4,        32'd16,       1'b0);
      drain();

      // Divide vectors
      issue(1'b1, 5'd10, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0);
      drain();
      issue(1'b1, 5'd11, 32'd5,        32'd0,        32'h00000000, 1'b1);
      drain();
      issue(1'b1, 5'd12, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1);
      drain();
      issue(1'b1, 5'd13, 32'd6,        32'd3,        32'd2,        1'b0);
      drain();
      issue(1'b1, 5'd15, 32'h80000000, 32'd2,        32'hC0000000, 1'b0);
      drain();
      issue(1'b1, 5'd16, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFF2, 1'b0);
      drain();

      // Start pulses while busy are ignored
      issue(1'b0, 5'd3, 32'd100, 32'hFFFFFFFB, 32'hFFFFFE0C, 1'b0);
      repeat (4) @(negedge clock);
      check("busy_mid", 32'(busy), 32'd1);
      ctrl_DIV = 1'b1; ctrl_writeReg = 5'd7; data_operandA = 32'd1; data_operandB = 32'd1;
      @(negedge clock);
      ctrl_MULT = 1'b1;
      @(negedge clock);
      ctrl_MULT = 1'b0; ctrl_DIV = 1'b0;
      drain();

      // Reset mid-operation aborts with no beat
      @(negedge clock);
      issue_now(1'b0, 5'd4, 32'd9, 32'd9, 32'd81, 1'b0, 1'b0);
      repeat (10) @(posedge clock);
      #2;
      check("busy_pre_rst", 32'(busy), 32'd1);
      ctrl_reset_n = 1'b0;
      #1;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_rdy",  32'(data_resultRDY), 32'd0);
      check("abort_we",   32'(wb_writeEnable), 32'd0);
      repeat (3) @(negedge clock);
      ctrl_reset_n = 1'b1;
      repeat (40) @(negedge clock);
      issue(1'b0, 5'd5, 32'd2, 32'd3, 32'd6, 1'b0);
      drain();

      // Back-to-back: new start presented during DONE
      issue(1'b0, 5'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 1'b0);
      for (int i = 0; i < 60 && !data_resultRDY; i++) @(negedge clock);
      check("b2b_done_seen", 32'(data_resultRDY), 32'd1);
      issue_now(1'b1, 5'd2, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 1'b1);
      drain();

      repeat (5) @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
